// File: rtl/laundromat_dispatch_scheduler.sv
// rtl/laundromat_dispatch_scheduler.sv - FIFO-fed round-robin dispatcher for a bank of washing machines
//
// Purpose: queues paid wash requests from the kiosk and hands each one to a free
// washing-machine controller. Free machines are picked round-robin. The scheduler
// tracks which machines are busy from their wash_done outputs and fans out a
// global pause to the busy ones.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   req_valid      kiosk has a paid request
//   req_double     the request is a double wash
//   req_ready      a request can be accepted this cycle
//   pause_all      operator pause: freeze busy machines and hold dispatch
//   wash_done_i    per-machine wash_done from the controllers
//   coin_o         per-machine coin pulse, one cycle long
//   double_wash_o  per-machine double_wash, held while the machine is busy
//   timer_pause_o  per-machine timer_pause
//   busy_o         per-machine busy flag
//   queue_count    number of requests waiting in the FIFO
//   served_count   number of completed washes, saturating
module laundromat_dispatch_scheduler #(
  parameter int N_MACHINES  = 4,
  parameter int QUEUE_DEPTH = 8,
  parameter int CNT_W       = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  input  logic                             req_double,
  output logic                             req_ready,
  input  logic                             pause_all,
  input  logic [N_MACHINES-1:0]            wash_done_i,
  output logic [N_MACHINES-1:0]            coin_o,
  output logic [N_MACHINES-1:0]            double_wash_o,
  output logic [N_MACHINES-1:0]            timer_pause_o,
  output logic [N_MACHINES-1:0]            busy_o,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count,
  output logic [CNT_W-1:0]                 served_count
);

  localparam int QC_W  = $clog2(QUEUE_DEPTH + 1);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int RR_W  = $clog2(N_MACHINES);

  // Each queue entry carries only the double-wash flag.
  logic [QUEUE_DEPTH-1:0] fifo_dbl;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [RR_W-1:0]        rr_ptr;
  logic [N_MACHINES-1:0]  wash_done_q;
  logic [N_MACHINES-1:0]  release_mask;
  logic                   push;
  logic                   pop;
  logic                   found;
  logic [RR_W-1:0]        pick;
  logic [CNT_W:0]         n_release;
  logic [CNT_W:0]         served_sum;

  assign req_ready = (queue_count < QC_W'(QUEUE_DEPTH));
  // A full queue refuses pushes even if a pop frees a slot on the same edge.
  assign push      = req_valid & req_ready;

  // Only a rising wash_done on a machine we own counts; a level held high does not.
  assign release_mask = wash_done_i & ~wash_done_q & busy_o;

  // First free machine scanning from rr_ptr upward, wrapping at N_MACHINES.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_MACHINES; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_MACHINES) idx = idx - N_MACHINES;
      if (!found && !busy_o[idx]) begin
        found = 1'b1;
        pick  = RR_W'(idx);
      end
    end
  end

  // Uses the registered busy vector, so a machine released this edge is only
  // dispatchable from the next one.
  assign pop = (queue_count != '0) & ~pause_all & found;

  always_comb begin
    n_release = '0;
    for (int i = 0; i < N_MACHINES; i++) begin
      n_release = n_release + (CNT_W + 1)'(release_mask[i]);
    end
    served_sum = {1'b0, served_count} + n_release;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_dbl      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rr_ptr        <= '0;
      wash_done_q   <= '0;
      coin_o        <= '0;
      double_wash_o <= '0;
      timer_pause_o <= '0;
      busy_o        <= '0;
      queue_count   <= '0;
      served_count  <= '0;
    end else begin
      wash_done_q   <= wash_done_i;
      coin_o        <= '0;
      timer_pause_o <= {N_MACHINES{pause_all}} & busy_o;

      if (push) begin
        fifo_dbl[wr_ptr] <= req_double;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   queue_count <= queue_count + 1'b1;
        2'b01:   queue_count <= queue_count - 1'b1;
        default: queue_count <= queue_count;
      endcase

      busy_o        <= busy_o & ~release_mask;
      double_wash_o <= double_wash_o & ~release_mask;

      // pick is never in release_mask (free vs. busy), so these bit writes
      // cannot collide with the release above.
      if (pop) begin
        busy_o[pick]        <= 1'b1;
        coin_o[pick]        <= 1'b1;
        double_wash_o[pick] <= fifo_dbl[rd_ptr];
        rr_ptr              <= (int'(pick) == N_MACHINES - 1) ? '0 : pick + 1'b1;
      end

      served_count <= served_sum[CNT_W] ? '1 : served_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_laundromat_dispatch_scheduler.sv
// tb/tb_laundromat_dispatch_scheduler.sv - directed vector bench for laundromat_dispatch_scheduler
module tb_laundromat_dispatch_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_double;
  logic       req_ready;
  logic       pause_all;
  logic [3:0] wash_done_i;
  logic [3:0] coin_o;
  logic [3:0] double_wash_o;
  logic [3:0] timer_pause_o;
  logic [3:0] busy_o;
  logic [3:0] queue_count;
  logic [3:0] served_count;

  int n_cmp = 0;
  int n_bad = 0;

  laundromat_dispatch_scheduler #(
    .N_MACHINES (4),
    .QUEUE_DEPTH(8),
    .CNT_W      (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_double   (req_double),
    .req_ready    (req_ready),
    .pause_all    (pause_all),
    .wash_done_i  (wash_done_i),
    .coin_o       (coin_o),
    .double_wash_o(double_wash_o),
    .timer_pause_o(timer_pause_o),
    .busy_o       (busy_o),
    .queue_count  (queue_count),
    .served_count (served_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       valid;
    logic       dbl;
    logic       pause;
    logic [3:0] done;
    logic [3:0] coin;
    logic [3:0] busy;
    logic [3:0] dw;
    logic [3:0] tp;
    logic [3:0] qc;
    logic [3:0] served;
    logic       ready;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] coin, input logic [3:0] busy,
                           input logic [3:0] dw, input logic [3:0] tp, input logic [3:0] qc,
                           input logic [3:0] served, input logic ready);
    chk({tag, ".coin"},   coin_o,        coin);
    chk({tag, ".busy"},   busy_o,        busy);
    chk({tag, ".dbl"},    double_wash_o, dw);
    chk({tag, ".tpause"}, timer_pause_o, tp);
    chk({tag, ".qcount"}, queue_count,   qc);
    chk({tag, ".served"}, served_count,  served);
    chk({tag, ".ready"},  req_ready,     ready);
  endtask

  // Inputs are applied at a negedge; outputs are sampled at the next negedge,
  // i.e. after the posedge that consumed these inputs.
  task automatic drive(input logic r, input logic v, input logic d, input logic p,
                       input logic [3:0] w);
    rst         = r;
    req_valid   = v;
    req_double  = d;
    pause_all   = p;
    wash_done_i = w;
    @(negedge clk);
  endtask

  initial begin
    int accepts;

    rst = 1'b1; req_valid = 1'b0; req_double = 1'b0; pause_all = 1'b0; wash_done_i = 4'b0000;

    //           rst   vld   dbl   pau   done     coin     busy     dw       tp       qc  srv  rdy
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'd0, 4'd0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'd1, 4'd0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'd0, 4'd0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'd0, 4'd0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'd0, 4'd1, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'd0, 4'd0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'd1, 4'd0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'd1, 4'd0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0010, 4'b0011, 4'b0010, 4'b0000, 4'd1, 4'd0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0100, 4'b0111, 4'b0010, 4'b0000, 4'd1, 4'd0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 4'b1111, 4'b1010, 4'b0000, 4'd1, 4'd0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b1010, 4'b0000, 4'd1, 4'd0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0000, 4'b1011, 4'b1010, 4'b0000, 4'd1, 4'd1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0100, 4'b1111, 4'b1010, 4'b0000, 4'd0, 4'd1, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0000, 4'b1111, 4'b1010, 4'b0000, 4'd0, 4'd1, 1'b1};

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].dbl, vecs[i].pause, vecs[i].done);
      check_all($sformatf("v%0d", i), vecs[i].coin, vecs[i].busy, vecs[i].dw, vecs[i].tp,
                vecs[i].qc, vecs[i].served, vecs[i].ready);
    end

    // Fill: four requests go to machines, eight more fill the queue.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    rst = 1'b0; req_valid = 1'b1; req_double = 1'b0;
    accepts = 0;
    for (int c = 0; c < 40; c++) begin
      if (!req_ready) break;
      accepts++;
      @(negedge clk);
    end
    chk("full.accepts", accepts, 12);
    chk("full.qcount", queue_count, 8);
    chk("full.busy", busy_o, 4'b1111);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    chk("full.hold_qcount", queue_count, 8);
    chk("full.hold_ready", req_ready, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b0001);
    check_all("full.release", 4'b0000, 4'b1110, 4'b0000, 4'b0000, 4'd8, 4'd1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b0001);
    check_all("full.pop_no_push", 4'b0001, 4'b1111, 4'b0000, 4'b0000, 4'd7, 4'd1, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b0001);
    check_all("full.refill", 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'd8, 4'd1, 1'b0);

    // Pause with machines 0,1 busy and two requests queued.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
    check_all("pause.enter", 4'b0000, 4'b0011, 4'b0000, 4'b0011, 4'd2, 4'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    check_all("pause.hold", 4'b0000, 4'b0011, 4'b0000, 4'b0011, 4'd2, 4'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);
    check_all("pause.release", 4'b0000, 4'b0010, 4'b0000, 4'b0011, 4'd2, 4'd1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    check_all("pause.after_rel", 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'd2, 4'd1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    check_all("pause.resume_m2", 4'b0100, 4'b0110, 4'b0000, 4'b0000, 4'd1, 4'd1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    check_all("pause.resume_m3", 4'b1000, 4'b1110, 4'b0000, 4'b0000, 4'd0, 4'd1, 1'b1);

    // wash_done[3] high from reset: only a fresh rising edge frees machine 3.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b1000);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b1000);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
    check_all("level.dispatch_m3", 4'b1000, 4'b1111, 4'b0000, 4'b0000, 4'd0, 4'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
    chk("level.held_busy", busy_o, 4'b1111);
    chk("level.held_served", served_count, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    chk("level.fall_busy", busy_o, 4'b1111);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
    chk("level.rise_busy", busy_o, 4'b0111);
    chk("level.rise_served", served_count, 1);

    // Mid-operation reset with three queued and all machines busy.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
    check_all("flush.before", 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'd3, 4'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
    check_all("flush.after", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'd0, 4'd0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    check_all("flush.rr_restart", 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'd0, 4'd0, 1'b1);

    // Simultaneous releases are each counted; the counter saturates at 15.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      chk($sformatf("sat%0d.busy", r), busy_o, 4'b1111);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
      chk($sformatf("sat%0d.served", r), served_count, (r == 3) ? 15 : 4 * (r + 1));
      chk($sformatf("sat%0d.freed", r), busy_o, 4'b0000);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
